// File: rtl/left_shift_pkg.sv
// rtl/left_shift_pkg.sv - shared constants and helpers for the left_shift block
//
// Purpose : default data width, shift-amount width derivation and the
//           shift amount the datapath uses for branch/jump offsets.
// Ports   : none (package).
// Macro   : LEFT_SHIFT_OVERFLOW_EN (used by left_shift and left_shift_stage).
package left_shift_pkg;

  // Default datapath width in bits (power of two, >= 2).
  localparam int DEFAULT_WIDTH = 32;

  // Word offset -> byte offset for branch and jump targets.
  localparam int BRANCH_SHAMT = 2;

  // Number of shift-amount bits (and barrel stages) for a given width.
  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/left_shift_stage.sv
// rtl/left_shift_stage.sv - one fixed-distance stage of the barrel shifter
//
// Purpose : conditionally shifts its operand left by DIST bits.
// Ports   : en       - apply the shift when 1, pass through when 0
//           data_in  - operand
//           data_out - en ? data_in << DIST : data_in
//           ovf_out  - (LEFT_SHIFT_OVERFLOW_EN only) OR of the bits this
//                      stage pushes past the MSB
// Macro   : LEFT_SHIFT_OVERFLOW_EN
module left_shift_stage
  import left_shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIST  = 1
) (
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
`ifdef LEFT_SHIFT_OVERFLOW_EN
  ,
  output logic             ovf_out
`endif
);

  assign data_out = en ? (data_in << DIST) : data_in;

`ifdef LEFT_SHIFT_OVERFLOW_EN
  // The top DIST bits are exactly the ones discarded by this stage.
  assign ovf_out = en & (|data_in[WIDTH-1 -: DIST]);
`endif

endmodule

// File: rtl/left_shift.sv
// rtl/left_shift.sv - registered logical left shifter with valid tracking
//
// Purpose : data_out = (data_in << shamt) truncated to WIDTH, one cycle of
//           latency, one operand accepted per cycle, no backpressure.
// Ports   : clk       - rising-edge clock
//           rst_n     - synchronous active-low reset
//           in_valid  - data_in/shamt valid this cycle
//           data_in   - operand
//           shamt     - unsigned shift amount 0..WIDTH-1
//           out_valid - data_out holds a fresh result
//           data_out  - registered result (holds when no operand arrives)
//           overflow  - (LEFT_SHIFT_OVERFLOW_EN only) a 1 bit was shifted
//                       out past the MSB
// Macro   : LEFT_SHIFT_OVERFLOW_EN
module left_shift
  import left_shift_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = shamt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   data_out
`ifdef LEFT_SHIFT_OVERFLOW_EN
  ,
  output logic               overflow
`endif
);

  // Stage k consumes stage_data[k] and produces stage_data[k+1].
  logic [SHAMT_W:0][WIDTH-1:0] stage_data;
  logic [WIDTH-1:0]            shifted;

  assign stage_data[0] = data_in;
  assign shifted       = stage_data[SHAMT_W];

`ifdef LEFT_SHIFT_OVERFLOW_EN
  logic [SHAMT_W-1:0] stage_ovf;
  logic               shifted_ovf;

  // Bits lost in any stage are bits of data_in above WIDTH-1-shamt, so the
  // OR of all per-stage terms is the overall overflow.
  assign shifted_ovf = |stage_ovf;
`endif

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    left_shift_stage #(
      .WIDTH(WIDTH),
      .DIST (1 << k)
    ) u_stage (
      .en      (shamt[k]),
      .data_in (stage_data[k]),
      .data_out(stage_data[k+1])
`ifdef LEFT_SHIFT_OVERFLOW_EN
      ,
      .ovf_out (stage_ovf[k])
`endif
    );
  end

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
`ifdef LEFT_SHIFT_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  // Result registers only load on a valid operand so idle cycles do not
  // toggle the output bus.
  always_comb begin
    valid_d = in_valid;
    data_d  = data_q;
`ifdef LEFT_SHIFT_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    if (in_valid) begin
      data_d = shifted;
`ifdef LEFT_SHIFT_OVERFLOW_EN
      ovf_d  = shifted_ovf;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef LEFT_SHIFT_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef LEFT_SHIFT_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign data_out  = data_q;
`ifdef LEFT_SHIFT_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_left_shift.sv
// tb/tb_left_shift.sv - self-checking bench for left_shift
module tb_left_shift;
  import left_shift_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        out_valid;
  logic [31:0] data_out;
`ifdef LEFT_SHIFT_OVERFLOW_EN
  logic        overflow;
`endif

  left_shift #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .data_in  (data_in),
    .shamt    (shamt),
    .out_valid(out_valid),
    .data_out (data_out)
`ifdef LEFT_SHIFT_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: what the outputs should show after the latest edge.
  logic [31:0] exp_data;
  logic        exp_valid;
  logic        exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference, then compare.
  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] s, input logic rn);
    logic [63:0] wide;
    @(negedge clk);
    in_valid = v;
    data_in  = d;
    shamt    = s;
    rst_n    = rn;
    @(posedge clk);
    #1;
    wide = 64'(d) << s;
    if (!rn) begin
      exp_data  = 32'h0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
    end else if (v) begin
      exp_data  = wide[31:0];
      exp_valid = 1'b1;
      exp_ovf   = |wide[63:32];
    end else begin
      exp_valid = 1'b0;
    end
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("data_out", data_out, exp_data);
`ifdef LEFT_SHIFT_OVERFLOW_EN
    check("overflow", 32'(overflow), 32'(exp_ovf));
`endif
  endtask

  initial begin
    exp_data  = 32'h0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = 32'h0;
    shamt     = 5'd0;

    // Reset state, with an operand presented during reset being dropped.
    step(1'b0, 32'h0, 5'd0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b0);
    check("reset_data", data_out, 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);

    // Branch offsets.
    step(1'b1, 32'h0000_0001, 5'(BRANCH_SHAMT), 1'b1);
    check("branch_1", data_out, 32'h0000_0004);
    step(1'b1, 32'hFFFF_FFFF, 5'(BRANCH_SHAMT), 1'b1);
    check("branch_ff", data_out, 32'hFFFF_FFFC);

    // Identity and extremes.
    step(1'b1, 32'hA5A5_A5A5, 5'd0, 1'b1);
    check("identity", data_out, 32'hA5A5_A5A5);
    step(1'b1, 32'h0000_0001, 5'd31, 1'b1);
    check("shift31", data_out, 32'h8000_0000);
    step(1'b1, 32'h8000_0000, 5'd1, 1'b1);
    check("msb_out", data_out, 32'h0000_0000);

    // Back-to-back throughput.
    step(1'b1, 32'h1, 5'd1, 1'b1);
    check("b2b_0", data_out, 32'h2);
    step(1'b1, 32'h3, 5'd4, 1'b1);
    check("b2b_1", data_out, 32'h30);
    step(1'b1, 32'h7, 5'd8, 1'b1);
    check("b2b_2", data_out, 32'h700);
    check("b2b_valid", 32'(out_valid), 32'h1);

    // Bubble: output holds, valid drops.
    step(1'b0, 32'h1357_9BDF, 5'd7, 1'b1);
    check("bubble_hold", data_out, 32'h700);
    step(1'b1, 32'h5, 5'd2, 1'b1);
    check("after_bubble", data_out, 32'h14);

    // Reset mid-stream, then resume.
    step(1'b1, 32'h1234_5678, 5'd4, 1'b0);
    check("midrst_data", data_out, 32'h0);
    step(1'b1, 32'h1234_5678, 5'd4, 1'b1);
    check("post_rst", data_out, 32'h2345_6780);

    // Every shift amount with random operands.
    for (int s = 0; s < 32; s++) begin
      for (int r = 0; r < 3; r++) begin
        step(1'b1, $urandom, 5'(s), 1'b1);
      end
    end

    // Random stream with bubbles and occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
           ($urandom_range(0, 49) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
